// File: rtl/router_pkt_tx.sv
// Packet transmitter for a 3-port router: buffers payload bytes in a FIFO and emits
// header, payload and XOR parity, honouring the router's busy stall.
module router_pkt_tx #(
   parameter int BUF_DEPTH = 64
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       start,
   input  logic [1:0] dest_addr,
   input  logic [5:0] payload_len,
   input  logic       busy,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       in_packet,
   output logic       ready,
   output logic       done,
   output logic       err,
   output logic [6:0] buf_count
);

   localparam int AW = $clog2(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, HDR, PLD, PAR} state_t;

   state_t        state, state_d;
   logic [7:0]    mem [BUF_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [6:0]    count;
   logic [5:0]    rem_q, rem_d;
   logic [7:0]    parity, parity_d, data_d;
   logic          valid_d, done_d, err_d, push, pop;

   assign in_packet = (state != IDLE);
   assign ready     = (state == IDLE);
   assign buf_count = count;
   assign rd_next   = rd_ptr + 1'b1;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a latch behind.
      state_d  = state;
      data_d   = data_out;
      valid_d  = pkt_valid;
      parity_d = parity;
      rem_d    = rem_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      push     = wr_en && (count != 7'(BUF_DEPTH));
      err_d    = wr_en && !push;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (payload_len != 6'd0 && dest_addr != 2'd3 && count >= {1'b0, payload_len}) begin
                  state_d  = HDR;
                  data_d   = {payload_len, dest_addr};
                  valid_d  = 1'b1;
                  parity_d = {payload_len, dest_addr};
                  rem_d    = payload_len;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         HDR: begin
            // First payload byte is only presented here; it is popped once accepted.
            if (!busy) begin
               state_d  = PLD;
               data_d   = mem[rd_ptr];
               parity_d = parity ^ mem[rd_ptr];
            end
         end
         PLD: begin
            if (!busy) begin
               pop   = 1'b1;
               rem_d = rem_q - 6'd1;
               if (rem_q == 6'd1) begin
                  state_d = PAR;
                  data_d  = parity;
                  valid_d = 1'b0;
               end else begin
                  data_d   = mem[rd_next];
                  parity_d = parity ^ mem[rd_next];
               end
            end
         end
         PAR: begin
            if (!busy) begin
               state_d = IDLE;
               data_d  = 8'd0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_d;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         data_out  <= 8'd0;
         pkt_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         parity    <= 8'd0;
         rem_q     <= 6'd0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= 7'd0;
      end else begin
         data_out  <= data_d;
         pkt_valid <= valid_d;
         done      <= done_d;
         err       <= err_d;
         parity    <= parity_d;
         rem_q     <= rem_d;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_next;
         unique case ({push, pop})
            2'b10:   count <= count + 7'd1;
            2'b01:   count <= count - 7'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; zeroed pointers and count make old contents unreachable.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a byte-queue model predicts every cycle
// of each packet (header, payload, parity, done) and the buffer occupancy.
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       start = 1'b0;
   logic [1:0] dest_addr = 2'd0;
   logic [5:0] payload_len = 6'd0;
   logic       busy = 1'b0;
   logic [7:0] data_out;
   logic       pkt_valid, in_packet, ready, done, err;
   logic [6:0] buf_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] model_q[$];
   int mcount = 0;

   router_pkt_tx #(.BUF_DEPTH(64)) dut (
      .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
      .start(start), .dest_addr(dest_addr), .payload_len(payload_len), .busy(busy),
      .data_out(data_out), .pkt_valid(pkt_valid), .in_packet(in_packet), .ready(ready),
      .done(done), .err(err), .buf_count(buf_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      n_checks++;
      if (data_out !== 8'd0 || pkt_valid !== 1'b0 || in_packet !== 1'b0 || ready !== 1'b1 ||
          done !== 1'b0 || err !== 1'b0 || buf_count !== 7'd0) begin
         n_fail++;
         $display("FAIL %s: data_out=%h pkt_valid=%b in_packet=%b ready=%b done=%b err=%b buf_count=%0d, required 00 0 0 1 0 0 0",
                  tag, data_out, pkt_valid, in_packet, ready, done, err, buf_count);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      logic drop;
      drop = (mcount == 64);
      wr_en = 1'b1;
      wr_data = b;
      step();
      wr_en = 1'b0;
      if (!drop) begin
         model_q.push_back(b);
         mcount++;
      end
      n_checks++;
      if (err !== drop) begin
         n_fail++;
         $display("FAIL write_err: err=%b required %b (count before write %0d)", err, drop, mcount);
      end
      n_checks++;
      if (buf_count !== 7'(mcount)) begin
         n_fail++;
         $display("FAIL write_count: buf_count=%0d required %0d", buf_count, mcount);
      end
   endtask

   // mode 0: no stall; 1: random stalls, writes and input noise; 2: two-cycle stall on 2nd payload byte
   task automatic run_packet(input logic [5:0] len, input logic [1:0] addr, input int mode, input string tag);
      logic [7:0] exp_q[$];
      logic [7:0] par, b;
      int idx, stall_left;
      logic stalled_once, finished, bz, wr, pop;
      exp_q.push_back({len, addr});
      par = {len, addr};
      for (int i = 0; i < int'(len); i++) begin
         b = model_q.pop_front();
         exp_q.push_back(b);
         par ^= b;
      end
      exp_q.push_back(par);

      start = 1'b1; dest_addr = addr; payload_len = len; busy = 1'b0;
      step();
      start = 1'b0;
      n_checks++;
      if (data_out !== exp_q[0] || pkt_valid !== 1'b1 || in_packet !== 1'b1 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s header: data_out=%h pkt_valid=%b in_packet=%b ready=%b, required %h 1 1 0",
                  tag, data_out, pkt_valid, in_packet, ready, exp_q[0]);
      end

      idx = 0; stall_left = 0; stalled_once = 1'b0; finished = 1'b0;
      for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
         bz = 1'b0;
         if (mode == 1) bz = ($urandom_range(0, 2) == 0);
         if (mode == 2) begin
            if (idx == 2 && !stalled_once) begin
               stall_left = 2;
               stalled_once = 1'b1;
            end
            bz = (stall_left > 0);
            if (stall_left > 0) stall_left--;
         end
         wr = (mode == 1) && (mcount < 56) && ($urandom_range(0, 3) == 0);
         busy = bz; wr_en = wr; wr_data = 8'($urandom);
         if (mode == 1) begin
            start = 1'($urandom); dest_addr = 2'($urandom); payload_len = 6'($urandom);
         end
         pop = (idx >= 1) && (idx <= int'(len)) && !bz;
         step();
         if (wr) begin
            model_q.push_back(wr_data);
            mcount++;
         end
         if (pop) mcount--;
         if (!bz) idx++;

         n_checks++;
         if (buf_count !== 7'(mcount) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s count/err: buf_count=%0d err=%b, required %0d 0", tag, buf_count, err, mcount);
         end
         n_checks++;
         if (idx == int'(len) + 2) begin
            finished = 1'b1;
            if (done !== 1'b1 || ready !== 1'b1 || pkt_valid !== 1'b0 || data_out !== 8'd0) begin
               n_fail++;
               $display("FAIL %s end: done=%b ready=%b pkt_valid=%b data_out=%h, required 1 1 0 00",
                        tag, done, ready, pkt_valid, data_out);
            end
         end else if (done !== 1'b0 || in_packet !== 1'b1 || data_out !== exp_q[idx] ||
                      pkt_valid !== (idx <= int'(len))) begin
            n_fail++;
            $display("FAIL %s byte %0d: data_out=%h pkt_valid=%b done=%b in_packet=%b, required %h %b 0 1",
                     tag, idx, data_out, pkt_valid, done, in_packet, exp_q[idx], (idx <= int'(len)));
         end
      end
      wr_en = 1'b0; start = 1'b0; busy = 1'b0;
      if (!finished) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: packet never completed, reached byte %0d of %0d", tag, idx, len + 2);
      end
   endtask

   task automatic test_reset();
      #12;
      check_idle_outputs("reset_held");
      #5 resetn = 1'b1;
      step();
      check_idle_outputs("reset_released");
   endtask

   task automatic test_basic();
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
      run_packet(6'd3, 2'd2, 0, "basic");
   endtask

   task automatic test_stall();
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
      run_packet(6'd3, 2'd2, 2, "stall");
   endtask

   task automatic test_bad_start();
      logic [5:0] lens [3] = '{6'd0, 6'd2, 6'd5};
      logic [1:0] addrs[3] = '{2'd1, 2'd3, 2'd0};
      write_byte(8'hA5); write_byte(8'h5A);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; payload_len = lens[i]; dest_addr = addrs[i];
         step();
         start = 1'b0;
         n_checks++;
         if (err !== 1'b1 || ready !== 1'b1 || pkt_valid !== 1'b0 || in_packet !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_start_%0d: err=%b ready=%b pkt_valid=%b in_packet=%b, required 1 1 0 0",
                     i, err, ready, pkt_valid, in_packet);
         end
         step();
         n_checks++;
         if (err !== 1'b0 || buf_count !== 7'd2) begin
            n_fail++;
            $display("FAIL bad_start_clear_%0d: err=%b buf_count=%0d, required 0 2", i, err, buf_count);
         end
      end
      run_packet(6'd2, 2'd1, 0, "drain");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 65; i++) write_byte(8'($urandom));
      n_checks++;
      if (buf_count !== 7'd64) begin
         n_fail++;
         $display("FAIL overflow_count: buf_count=%0d required 64", buf_count);
      end
      run_packet(6'd63, 2'd0, 0, "overflow_a");
      run_packet(6'd1, 2'd2, 0, "overflow_b");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) write_byte(8'($urandom));
      start = 1'b1; payload_len = 6'd4; dest_addr = 2'd0;
      step();
      start = 1'b0;
      step();
      step();
      #3 resetn = 1'b0;
      #1;
      check_idle_outputs("reset_mid");
      model_q.delete();
      mcount = 0;
      @(negedge clock);
      resetn = 1'b1;
      step();
      check_idle_outputs("reset_mid_after");
      write_byte(8'hC3); write_byte(8'h3C); write_byte(8'h7E);
      run_packet(6'd3, 2'd1, 1, "post_reset");
   endtask

   task automatic test_back_to_back();
      write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
      run_packet(6'd1, 2'd0, 0, "b2b_first");
      run_packet(6'd2, 2'd1, 0, "b2b_second");
   endtask

   task automatic test_random();
      for (int p = 0; p < 8; p++) begin
         int len;
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) write_byte(8'($urandom));
         run_packet(6'(len), 2'($urandom_range(0, 2)), 1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_bad_start();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
